alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Operand-producing end of the ALU interface: accepts 16-bit instruction words from fetch, decodes them and reads the register file.
- Drives registered srcA, srcB and opSel toward the ALU with a valid/ready handshake.
- Holds a register scoreboard that stalls read-after-write hazards until writeback clears them.
- Sits between fetch and the execute stage.

Parameters:
- DATA_W, 16, operand width; decode assumes 16.
- REG_AW, 3, register address width; the scoreboard has 2**REG_AW bits.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_instr  in  16  instruction word.
- i_instrValid  in  1  fetch offers i_instr.
- o_instrReady  out  1  stage accepts i_instr this cycle.
- o_rdAddrA  out  REG_AW  regfile read address A (combinational from i_instr).
- o_rdAddrB  out  REG_AW  regfile read address B (combinational from i_instr).
- i_rdDataA  in  DATA_W  regfile read data A.
- i_rdDataB  in  DATA_W  regfile read data B.
- o_srcA  out  DATA_W  ALU operand A (registered).
- o_srcB  out  DATA_W  ALU operand B (registered).
- o_opSel  out  1  ALU op select (registered).
- o_dstReg  out  REG_AW  destination register (registered).
- o_issueValid  out  1  output register holds a valid op.
- i_issueReady  in  1  execute consumes the op.
- i_wbValid  in  1  writeback completes this cycle.
- i_wbReg  in  REG_AW  register written back.
- i_wbData  in  DATA_W  writeback data (used only with the optional feature).
- i_flush  in  1  discard the held op and block intake this cycle.

Behaviour:
- Decode:
  - op = i_instr[15:12]; rd = [11:9].
  - LBI (op == 4'b1000): flag = [8], imm = [7:0]. o_rdAddrA = rd; operand A = i_rdDataA; operand B = sign-extended imm; opSel = flag.
  - All other ops: o_rdAddrA = [8:6]; o_rdAddrB = [5:3]; operands = i_rdDataA/B; opSel = 0.
  - Unused address ports read 0.
- Sources checked for hazard:
  - LBI with flag=1: rd.
  - LBI with flag=0: none.
  - Other ops: [8:6] and [5:3].
- hazard = any checked source busy in scoreboard (registered state only).
- o_instrReady = !i_flush && !hazard && (!o_issueValid || i_issueReady).
- Accept (i_instrValid && o_instrReady): capture operands, opSel, rd into the output register; o_issueValid = 1 next cycle.
- Output handshake is done when o_issueValid && i_issueReady.
  - No new accept in that cycle: o_issueValid = 0 next cycle.
  - A new accept in the same cycle: back-to-back at 1 op/cycle.
- Outputs hold stable while o_issueValid && !i_issueReady.
- Scoreboard:
  - Busy[rd] is set on the output handshake.
  - Busy[i_wbReg] is cleared on i_wbValid.
  - Set and clear of the same register in one cycle: set wins.
  - A clear for a non-busy register is ignored.
- Hazard released by writeback: the instruction is accepted the cycle after the clear, giving one stall cycle minimum (regfile is written on the same edge).
- i_flush:
  - o_issueValid = 0 next cycle; no busy bit is set for the discarded op.
  - No intake that cycle; scoreboard clears are still honoured.
- Reset (async):
  - o_issueValid = 0; o_srcA = o_srcB = 0; o_opSel = 0; o_dstReg = 0; scoreboard = 0.
  - Mid-operation reset drops any held op silently.
- Latency: 1 cycle from accept to o_issueValid.

Optional Feature:
- ALU_ISSUE_BYPASS_EN defined:
  - A checked source whose busy bit is cleared by i_wbValid in the same cycle is not a hazard.
  - Its operand is taken from i_wbData instead of regfile data; this removes the stall cycle.
  - For LBI flag=1, bypass applies to operand A.
- Undefined:
  - i_wbData is ignored; behaviour is exactly as above.

Test Plan:
- Reset, then LBI 0x8A12 (rd=5, flag=0, imm=0x12) -> next cycle o_issueValid=1, o_srcB=0x0012, o_opSel=0, o_dstReg=5; handshake sets busy[5].
- LBI 0x8980 (rd=4, flag=1, imm=0x80) with r4=0x00AB -> o_srcA=0x00AB, o_srcB=0xFF80, o_opSel=1.
- Hazard, without bypass:
  - Issue a write to r2, then a register op reading r2 ([8:6]=2) -> o_instrReady=0 until i_wbValid with i_wbReg=2.
  - Op accepted the following cycle; 1 stall cycle after writeback.
- Hazard, with ALU_ISSUE_BYPASS_EN: same sequence, i_wbData=0x1234 -> accepted in the writeback cycle; o_srcA=0x1234.
- Backpressure: hold i_issueReady=0 for 3 cycles with 2 instructions offered -> outputs stable, o_instrReady=0; i_issueReady=1 -> one op per cycle, order preserved.
- i_flush while o_issueValid=1 -> o_issueValid=0 next cycle; busy[o_dstReg] stays 0. Assert i_rstn=0 mid-stall -> all outputs and scoreboard 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes 16-bit instructions, reads regfile operands and stalls RAW hazards
// with a register scoreboard. Define ALU_ISSUE_BYPASS_EN to forward writeback data past the stall.
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [15:0]       i_instr,
  input  logic              i_instrValid,
  output logic              o_instrReady,
  output logic [REG_AW-1:0] o_rdAddrA,
  output logic [REG_AW-1:0] o_rdAddrB,
  input  logic [DATA_W-1:0] i_rdDataA,
  input  logic [DATA_W-1:0] i_rdDataB,
  output logic [DATA_W-1:0] o_srcA,
  output logic [DATA_W-1:0] o_srcB,
  output logic              o_opSel,
  output logic [REG_AW-1:0] o_dstReg,
  output logic              o_issueValid,
  input  logic              i_issueReady,
  input  logic              i_wbValid,
  input  logic [REG_AW-1:0] i_wbReg,
  input  logic [DATA_W-1:0] i_wbData,
  input  logic              i_flush
);

  localparam int         NREG   = 2**REG_AW;
  localparam logic [3:0] OP_LBI = 4'b1000;

  logic              is_lbi;
  logic [REG_AW-1:0] rd, reg_a, reg_b;
  logic              chk_a, chk_b;
  logic [DATA_W-1:0] imm_ext;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_lbi = (i_instr[15:12] == OP_LBI);
    rd     = i_instr[11:9];
    reg_a  = i_instr[8:6];
    reg_b  = i_instr[5:3];
    chk_a  = 1'b1;
    chk_b  = 1'b1;
    if (is_lbi) begin
      reg_a = rd;
      reg_b = '0;
      chk_a = i_instr[8];
      chk_b = 1'b0;
    end
  end

  assign imm_ext   = {{(DATA_W-8){i_instr[7]}}, i_instr[7:0]};
  assign o_rdAddrA = reg_a;
  assign o_rdAddrB = reg_b;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d;
  logic              op_sel_q, op_sel_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic out_hs, set_busy, accept, hazard, byp_a, byp_b;

  assign out_hs   = valid_q && i_issueReady;
  assign set_busy = out_hs && !i_flush;

`ifdef ALU_ISSUE_BYPASS_EN
  // A source is forwarded only if this cycle's writeback really clears its busy bit.
  logic [NREG-1:0] clr_now;
  always_comb begin
    clr_now = '0;
    if (i_wbValid) clr_now[i_wbReg] = busy_q[i_wbReg];
    if (set_busy)  clr_now[dst_q]   = 1'b0;
  end
  assign byp_a = chk_a && clr_now[reg_a];
  assign byp_b = chk_b && clr_now[reg_b];
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign hazard       = (chk_a && busy_q[reg_a] && !byp_a) || (chk_b && busy_q[reg_b] && !byp_b);
  assign o_instrReady = !i_flush && !hazard && (!valid_q || i_issueReady);
  assign accept       = i_instrValid && o_instrReady;

  always_comb begin
    valid_d  = valid_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    op_sel_d = op_sel_q;
    dst_d    = dst_q;
    if (accept) begin
      valid_d  = 1'b1;
      src_a_d  = byp_a ? i_wbData : i_rdDataA;
      src_b_d  = is_lbi ? imm_ext : (byp_b ? i_wbData : i_rdDataB);
      op_sel_d = is_lbi && i_instr[8];
      dst_d    = rd;
    end else if (out_hs || i_flush) begin
      valid_d  = 1'b0;
    end
  end

  // Set is applied after clear so a same-register set/clear leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (i_wbValid) busy_d[i_wbReg] = 1'b0;
    if (set_busy)  busy_d[dst_q]   = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q  <= 1'b0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      op_sel_q <= 1'b0;
      dst_q    <= '0;
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset to drop stale hazards.
      busy_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      op_sel_q <= op_sel_d;
      dst_q    <= dst_d;
      busy_q   <= busy_d;
    end
  end

  assign o_issueValid = valid_q;
  assign o_srcA       = src_a_q;
  assign o_srcB       = src_b_q;
  assign o_opSel      = op_sel_q;
  assign o_dstReg     = dst_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode vector table, scoreboard of issued ops,
// and directed hazard / backpressure / flush / reset sequences.
module tb_alu_issue_stage;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [15:0] i_instr = '0;
  logic        i_instrValid = 1'b0;
  logic        o_instrReady;
  logic [2:0]  o_rdAddrA, o_rdAddrB;
  logic [15:0] i_rdDataA, i_rdDataB;
  logic [15:0] o_srcA, o_srcB;
  logic        o_opSel;
  logic [2:0]  o_dstReg;
  logic        o_issueValid;
  logic        i_issueReady = 1'b1;
  logic        i_wbValid = 1'b0;
  logic [2:0]  i_wbReg = '0;
  logic [15:0] i_wbData = '0;
  logic        i_flush = 1'b0;

  alu_issue_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_instr(i_instr), .i_instrValid(i_instrValid),
    .o_instrReady(o_instrReady), .o_rdAddrA(o_rdAddrA), .o_rdAddrB(o_rdAddrB),
    .i_rdDataA(i_rdDataA), .i_rdDataB(i_rdDataB), .o_srcA(o_srcA), .o_srcB(o_srcB),
    .o_opSel(o_opSel), .o_dstReg(o_dstReg), .o_issueValid(o_issueValid),
    .i_issueReady(i_issueReady), .i_wbValid(i_wbValid), .i_wbReg(i_wbReg),
    .i_wbData(i_wbData), .i_flush(i_flush)
  );

  always #5 i_clk = ~i_clk;

  logic [15:0] rf [8];
  assign i_rdDataA = rf[o_rdAddrA];
  assign i_rdDataB = rf[o_rdAddrB];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic        op;
    logic [2:0]  dst;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] tb_busy = '0;

`ifdef ALU_ISSUE_BYPASS_EN
  function automatic logic wb_hits(input logic [2:0] r, input logic set_v, input logic [2:0] set_r);
    return i_wbValid && (i_wbReg == r) && tb_busy[r] && !(set_v && set_r == r);
  endfunction
`endif

  function automatic exp_t model(input logic [15:0] ins, input logic set_v, input logic [2:0] set_r);
    exp_t m;
    m.dst = ins[11:9];
    if (ins[15:12] == 4'b1000) begin
      m.src_a = rf[ins[11:9]];
      m.src_b = {{8{ins[7]}}, ins[7:0]};
      m.op    = ins[8];
`ifdef ALU_ISSUE_BYPASS_EN
      if (ins[8] && wb_hits(ins[11:9], set_v, set_r)) m.src_a = i_wbData;
`endif
    end else begin
      m.src_a = rf[ins[8:6]];
      m.src_b = rf[ins[5:3]];
      m.op    = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
      if (wb_hits(ins[8:6], set_v, set_r)) m.src_a = i_wbData;
      if (wb_hits(ins[5:3], set_v, set_r)) m.src_b = i_wbData;
`endif
    end
    return m;
  endfunction

  // Scoreboard: compare the held op every valid cycle, pop on handshake or flush, push on accept.
  always @(negedge i_clk) begin : monitor
    exp_t       e;
    logic       set_v;
    logic [2:0] set_r;
    if (!i_rstn) begin
      sb_q.delete();
      tb_busy = '0;
    end else begin
      set_v = 1'b0;
      set_r = '0;
      if (o_issueValid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: issue valid with no expected op at %0t", $time);
        end else begin
          e = sb_q[0];
          check("sb_src_a", o_srcA, e.src_a);
          check("sb_src_b", o_srcB, e.src_b);
          check("sb_op_sel", o_opSel, e.op);
          check("sb_dst", o_dstReg, e.dst);
          set_v = i_issueReady && !i_flush;
          set_r = e.dst;
          if (i_issueReady || i_flush) void'(sb_q.pop_front());
        end
      end
      if (i_instrValid && o_instrReady) sb_q.push_back(model(i_instr, set_v, set_r));
      if (i_wbValid) tb_busy[i_wbReg] = 1'b0;
      if (set_v) tb_busy[set_r] = 1'b1;
    end
  end

  // Advance one cycle; the regfile write lands just after the edge, like a same-edge regfile.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (i_wbValid) rf[i_wbReg] = i_wbData;
  endtask

  task automatic idle();
    i_instrValid = 1'b0;
    i_issueReady = 1'b1;
    i_wbValid    = 1'b0;
    i_flush      = 1'b0;
  endtask

  task automatic writeback(input logic [2:0] r);
    i_wbValid = 1'b1;
    i_wbReg   = r;
    i_wbData  = rf[r];
    tick();
    i_wbValid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  addr_a;
    logic [2:0]  addr_b;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic        op;
    logic [2:0]  dst;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    vecs[0] = '{16'h8A12, 3'd5, 3'd0, 16'h5555, 16'h0012, 1'b0, 3'd5};
    vecs[1] = '{16'h8980, 3'd4, 3'd0, 16'h00AB, 16'hFF80, 1'b1, 3'd4};
    vecs[2] = '{16'h0650, 3'd1, 3'd2, 16'h1111, 16'h2222, 1'b0, 3'd3};
    vecs[3] = '{16'hFFB8, 3'd6, 3'd7, 16'h6666, 16'h7777, 1'b0, 3'd7};
    vecs[4] = '{16'h87FF, 3'd3, 3'd0, 16'h3333, 16'hFFFF, 1'b1, 3'd3};
    vecs[5] = '{16'h9028, 3'd0, 3'd5, 16'h0000, 16'h5555, 1'b0, 3'd0};
    vecs[6] = '{16'h807F, 3'd0, 3'd0, 16'h0000, 16'h007F, 1'b0, 3'd0};
    for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1111 * i);
    rf[4] = 16'h00AB;

    idle();
    tick();
    tick();
    check("reset_issue_valid", o_issueValid, 0);
    check("reset_src_a", o_srcA, 0);
    check("reset_src_b", o_srcB, 0);
    check("reset_op_sel", o_opSel, 0);
    check("reset_dst", o_dstReg, 0);
    i_rstn = 1'b1;
    tick();

    // Decode table: issue, consume immediately, then write back rd to clear its busy bit.
    for (int v = 0; v < 7; v++) begin
      i_instr      = vecs[v].instr;
      i_instrValid = 1'b1;
      #1;
      check("vec_rd_addr_a", o_rdAddrA, vecs[v].addr_a);
      check("vec_rd_addr_b", o_rdAddrB, vecs[v].addr_b);
      check("vec_ready", o_instrReady, 1);
      tick();
      i_instrValid = 1'b0;
      check("vec_issue_valid", o_issueValid, 1);
      check("vec_src_a", o_srcA, vecs[v].src_a);
      check("vec_src_b", o_srcB, vecs[v].src_b);
      check("vec_op_sel", o_opSel, vecs[v].op);
      check("vec_dst", o_dstReg, vecs[v].dst);
      tick();
      check("vec_drained", o_issueValid, 0);
      writeback(vecs[v].dst);
    end

    // RAW hazard on r2 released by writeback.
    i_instr      = 16'h0448;
    i_instrValid = 1'b1;
    tick();
    i_instrValid = 1'b0;
    tick();
    i_instr      = 16'h0680;
    i_instrValid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("hazard_stall", o_instrReady, 0);
      tick();
    end
    i_wbValid = 1'b1;
    i_wbReg   = 3'd2;
    i_wbData  = 16'h1234;
    #1;
`ifdef ALU_ISSUE_BYPASS_EN
    check("hazard_wb_cycle_ready", o_instrReady, 1);
    tick();
    i_wbValid = 1'b0;
`else
    check("hazard_wb_cycle_ready", o_instrReady, 0);
    tick();
    i_wbValid = 1'b0;
    #1;
    check("hazard_post_wb_ready", o_instrReady, 1);
    tick();
`endif
    i_instrValid = 1'b0;
    #1;
    check("hazard_issue_valid", o_issueValid, 1);
    check("hazard_src_a", o_srcA, 16'h1234);
    tick();
    writeback(3'd3);

    // Backpressure: two ops offered while execute stalls for three cycles.
    i_issueReady = 1'b0;
    i_instr      = 16'h8A12;
    i_instrValid = 1'b1;
    tick();
    i_instr = 16'h807F;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready_low", o_instrReady, 0);
      check("bp_valid_held", o_issueValid, 1);
      check("bp_src_b_stable", o_srcB, 16'h0012);
      check("bp_dst_stable", o_dstReg, 5);
      tick();
    end
    i_issueReady = 1'b1;
    #1;
    check("bp_release_ready", o_instrReady, 1);
    tick();
    i_instrValid = 1'b0;
    check("bp_second_valid", o_issueValid, 1);
    check("bp_second_src_b", o_srcB, 16'h007F);
    check("bp_second_dst", o_dstReg, 0);
    tick();
    check("bp_drained", o_issueValid, 0);
    writeback(3'd5);
    writeback(3'd0);

    // Flush discards the held op and blocks intake; its rd must not become busy.
    i_instr      = 16'h8C00;
    i_instrValid = 1'b1;
    tick();
    i_issueReady = 1'b0;
    i_flush      = 1'b1;
    #1;
    check("flush_blocks_intake", o_instrReady, 0);
    check("flush_held_valid", o_issueValid, 1);
    tick();
    i_flush      = 1'b0;
    i_issueReady = 1'b1;
    i_instr      = 16'h03B0;
    #1;
    check("flush_drops_op", o_issueValid, 0);
    check("flush_no_busy", o_instrReady, 1);
    tick();
    i_instrValid = 1'b0;
    tick();

    // Reset in the middle of a stall with an op held.
    i_issueReady = 1'b0;
    i_instr      = 16'h8E00;
    i_instrValid = 1'b1;
    tick();
    i_instr = 16'h0040;
    #1;
    check("stall_before_reset", o_instrReady, 0);
    #2;
    i_rstn = 1'b0;
    #2;
    check("async_reset_valid", o_issueValid, 0);
    check("async_reset_src_a", o_srcA, 0);
    check("async_reset_src_b", o_srcB, 0);
    check("async_reset_op_sel", o_opSel, 0);
    check("async_reset_dst", o_dstReg, 0);
    idle();
    tick();
    tick();
    i_rstn       = 1'b1;
    i_instr      = 16'h0040;
    i_instrValid = 1'b1;
    #1;
    check("reset_clears_scoreboard", o_instrReady, 1);
    tick();
    i_instrValid = 1'b0;
    tick();
    writeback(3'd0);
    tick();
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
